// File: rtl/wm_pixel_window.sv
// rtl/wm_pixel_window.sv - causal 2x2 pixel window with watermark symbol feed
// Presents current/left/up/up-left pixels plus one 2-bit symbol per accepted pixel.
module wm_pixel_window #(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int WM_SYMS = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [7:0] wm_byte,
  input  logic       wm_valid,
  output logic       wm_ready,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic [7:0] data3,
  output logic [7:0] data4,
  output logic [1:0] wm_data,
  output logic       out_valid,
  output logic       busy,
  output logic       frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int SW = $clog2(WM_SYMS + 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [SW-1:0] SYM_TOTAL = SW'(WM_SYMS);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t r_state, w_state_nxt;

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [SW-1:0] r_sym_cnt;
  logic [1:0]    r_sym_idx;
  logic          r_sym_avail;
  logic [7:0]    r_wm_byte;
  logic [7:0]    r_left, r_upleft;
  logic [7:0]    r_line [IMG_W];

  logic       w_interior, w_needs_sym, w_accept, w_wm_accept, w_last;
  logic [7:0] w_up;
  logic [1:0] w_sym;

  assign w_interior  = (r_row != '0) && (r_col != '0);
  assign w_needs_sym = w_interior && (r_sym_cnt < SYM_TOTAL);
  assign busy        = (r_state == S_RUN);
  assign pix_ready   = busy && (!w_needs_sym || r_sym_avail);
  assign wm_ready    = busy && !r_sym_avail;
  assign w_accept    = pix_valid && pix_ready;
  assign w_wm_accept = wm_valid && wm_ready;
  assign w_last      = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_up        = r_line[r_col];

  always_comb begin
    w_sym = r_wm_byte[7:6];
    case (r_sym_idx)
      2'd0: w_sym = r_wm_byte[7:6];
      2'd1: w_sym = r_wm_byte[5:4];
      2'd2: w_sym = r_wm_byte[3:2];
      2'd3: w_sym = r_wm_byte[1:0];
      default: w_sym = r_wm_byte[7:6];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN:  if (w_accept && w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_sym_cnt   <= '0;
      r_sym_idx   <= '0;
      r_sym_avail <= 1'b0;
      r_wm_byte   <= '0;
      r_left      <= '0;
      r_upleft    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_row       <= '0;
          r_col       <= '0;
          r_sym_cnt   <= '0;
          r_sym_idx   <= '0;
          r_sym_avail <= 1'b0;
        end
      end else begin
        // Refill and consumption never coincide: refill needs !avail, consumption needs avail.
        if (w_wm_accept) begin
          r_wm_byte   <= wm_byte;
          r_sym_avail <= 1'b1;
          r_sym_idx   <= '0;
        end
        if (w_accept) begin
          r_left   <= pix_in;
          r_upleft <= w_up;
          if (r_col == COL_LAST) begin
            r_col <= '0;
            r_row <= r_row + RW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
          if (w_needs_sym) begin
            r_sym_cnt <= r_sym_cnt + SW'(1);
            r_sym_idx <= r_sym_idx + 2'd1;
            if (r_sym_idx == 2'd3) r_sym_avail <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_line[r_col] <= pix_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1      <= '0;
      data2      <= '0;
      data3      <= '0;
      data4      <= '0;
      wm_data    <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= w_accept;
      frame_done <= w_accept && w_last;
      if (w_accept) begin
        data1 <= pix_in;
        // Border pixels replicate themselves so stale neighbours never leak out.
        if (w_interior) begin
          data2   <= r_left;
          data3   <= w_up;
          data4   <= r_upleft;
          wm_data <= w_needs_sym ? w_sym : 2'b00;
        end else begin
          data2   <= pix_in;
          data3   <= pix_in;
          data4   <= pix_in;
          wm_data <= 2'b00;
        end
      end
    end
  end
endmodule

// File: tb/tb_wm_pixel_window.sv
// tb/tb_wm_pixel_window.sv - directed bench for wm_pixel_window (4x3 frame)
module tb_wm_pixel_window;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start1, start2, pix_valid, wm_valid, sel;
  logic [7:0] pix_in, wm_byte;

  logic [7:0] a_d1, a_d2, a_d3, a_d4, b_d1, b_d2, b_d3, b_d4;
  logic [1:0] a_wm, b_wm;
  logic       a_ov, a_busy, a_fd, a_pr, a_wr, b_ov, b_busy, b_fd, b_pr, b_wr;

  wm_pixel_window #(.IMG_W(4), .IMG_H(3), .WM_SYMS(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(a_pr), .wm_byte(wm_byte), .wm_valid(wm_valid), .wm_ready(a_wr),
    .data1(a_d1), .data2(a_d2), .data3(a_d3), .data4(a_d4), .wm_data(a_wm),
    .out_valid(a_ov), .busy(a_busy), .frame_done(a_fd));

  wm_pixel_window #(.IMG_W(4), .IMG_H(3), .WM_SYMS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(b_pr), .wm_byte(wm_byte), .wm_valid(wm_valid), .wm_ready(b_wr),
    .data1(b_d1), .data2(b_d2), .data3(b_d3), .data4(b_d4), .wm_data(b_wm),
    .out_valid(b_ov), .busy(b_busy), .frame_done(b_fd));

  logic [7:0] m_d1, m_d2, m_d3, m_d4;
  logic [1:0] m_wm;
  logic       m_ov, m_busy, m_fd, m_pr, m_wr;
  assign m_d1   = sel ? b_d1 : a_d1;
  assign m_d2   = sel ? b_d2 : a_d2;
  assign m_d3   = sel ? b_d3 : a_d3;
  assign m_d4   = sel ? b_d4 : a_d4;
  assign m_wm   = sel ? b_wm : a_wm;
  assign m_ov   = sel ? b_ov : a_ov;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_fd   = sel ? b_fd : a_fd;
  assign m_pr   = sel ? b_pr : a_pr;
  assign m_wr   = sel ? b_wr : a_wr;

  int checks = 0;
  int failures = 0;
  int p, b;
  logic acc, wacc;
  logic [7:0] q1[$], q2[$], q3[$], q4[$];
  logic [1:0] qw[$];
  logic       qf[$];

  logic [7:0] wm_bytes [4] = '{8'hE4, 8'h1B, 8'h00, 8'h00};
  int e2[12]  = '{10, 11, 12, 13, 14, 14, 15, 16, 18, 18, 19, 20};
  int e3[12]  = '{10, 11, 12, 13, 14, 11, 12, 13, 18, 15, 16, 17};
  int e4[12]  = '{10, 11, 12, 13, 14, 10, 11, 12, 18, 14, 15, 16};
  int ew6[12] = '{0, 0, 0, 0, 0, 3, 2, 1, 0, 0, 0, 1};
  int ew2[12] = '{0, 0, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_d1"}, m_d1, 0);
    chk({tag, "_d2"}, m_d2, 0);
    chk({tag, "_d3"}, m_d3, 0);
    chk({tag, "_d4"}, m_d4, 0);
    chk({tag, "_wm"}, m_wm, 0);
    chk({tag, "_ov"}, m_ov, 0);
    chk({tag, "_fd"}, m_fd, 0);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_pix_ready"}, m_pr, 0);
    chk({tag, "_wm_ready"}, m_wr, 0);
  endtask

  // Called at a negedge; drives one cycle and checks the registered response.
  task automatic step(input logic pv, input logic wv, input logic st);
    pix_in    = 8'(10 + p);
    pix_valid = pv;
    wm_byte   = wm_bytes[b % 4];
    wm_valid  = wv;
    start1    = st && !sel;
    start2    = st && sel;
    #1;
    acc  = pv && m_pr;
    wacc = wv && m_wr;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
    chk("out_valid_latency", m_ov, acc);
    if (acc) begin
      chk($sformatf("d1_seq[%0d]", p), m_d1, 8'(10 + p));
      chk($sformatf("frame_done[%0d]", p), m_fd, (p == 11));
      q1.push_back(m_d1); q2.push_back(m_d2); q3.push_back(m_d3); q4.push_back(m_d4);
      qw.push_back(m_wm); qf.push_back(m_fd);
      p++;
    end
    if (wacc) b++;
    @(negedge clk);
  endtask

  task automatic check_frame(input bit two_syms);
    chk("out_count", q1.size(), 12);
    for (int k = 0; k < 12 && k < q1.size(); k++) begin
      chk($sformatf("d2[%0d]", k), q2[k], e2[k]);
      chk($sformatf("d3[%0d]", k), q3[k], e3[k]);
      chk($sformatf("d4[%0d]", k), q4[k], e4[k]);
      chk($sformatf("wm[%0d]", k), qw[k], two_syms ? ew2[k] : ew6[k]);
    end
  endtask

  // mode: 0 continuous, 1 pix_valid toggling, 2 wm starvation, 3 start mid-frame,
  //       4 reset after 5 pixels, 5 two-symbol instance with wm_valid dropped
  task automatic run_frame(input int mode);
    int stall;
    logic pv, wv, st;
    stall = 0;
    q1.delete(); q2.delete(); q3.delete(); q4.delete(); qw.delete(); qf.delete();
    p = 0;
    b = 0;
    step(1'b0, 1'b0, 1'b1);
    chk("busy_run", m_busy, 1);
    for (int cyc = 0; cyc < 200 && p < 12; cyc++) begin
      if (mode == 4 && p == 5) begin
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      pv = (mode != 1) || (cyc % 2 == 0);
      if (mode == 2) wv = (p >= 5) && (stall >= 4);
      else if (mode == 5) wv = (b == 0);
      else wv = 1'b1;
      if (mode == 2 && p == 5 && stall < 4) begin
        chk("starve_pix_ready", m_pr, 0);
        stall++;
      end
      if (mode == 5 && b >= 1) chk($sformatf("nowm_pix_ready[%0d]", p), m_pr, 1);
      st = (mode == 3) && (p == 6);
      step(pv, wv, st);
    end
    chk("frame_len", p, 12);
    chk("busy_done", m_busy, 0);
    check_frame(mode == 5);
  endtask

  initial begin
    sel = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    pix_valid = 1'b0;
    wm_valid = 1'b0;
    pix_in = '0;
    wm_byte = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(4);
    run_frame(0);
    run_frame(3);
    sel = 1'b1;
    run_frame(5);
    sel = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
